key_switch_input_comp: RTL and testbench

- Avalon-MM slave that the Nios reads to sample board pushbuttons (KEY) and slide switches (SW).
- Synchronises all inputs and debounces keys.
- Captures press edges in a sticky register and raises a maskable interrupt.
- Read-side counterpart of the write-only display peripherals; sits on the same system interconnect.

---
 rtl/key_switch_input_comp_if.sv | 39 +++
 rtl/key_switch_input_comp.sv | 181 ++++++++++++++++++
 tb/tb_key_switch_input_comp.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_switch_input_comp_if.sv
// ---------------------------------------------------------------------------
// key_switch_input_comp_if
//
// Purpose: Avalon-MM slave bundle for the key/switch input peripheral.
//
// Signals:
//   address   [1:0]   word address (0 SW, 1 KEY state, 2 edge capture, 3 mask)
//   read              read strobe
//   write             write strobe
//   writedata [31:0]  write data
//   readdata  [31:0]  read data, valid one cycle after read
//
// Modports:
//   master  - interconnect / Nios side, drives the command signals
//   slave   - peripheral side, drives readdata
// ---------------------------------------------------------------------------
interface key_switch_input_comp_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/key_switch_input_comp.sv
// ---------------------------------------------------------------------------
// key_switch_input_comp
//
// Purpose: Avalon-MM slave that lets the Nios sample the board pushbuttons
// (KEY, active-low) and slide switches (SW). All pins pass through two-flop
// synchronisers, keys are debounced, key presses are latched in a sticky
// write-1-to-clear edge-capture register and a maskable level interrupt is
// raised while any unmasked capture bit is set.
//
// Ports:
//   clk       system clock
//   reset_n   synchronous, active-low reset
//   avs       Avalon-MM slave (key_switch_input_comp_if.slave)
//   key_n     raw pushbuttons, active-low
//   sw        raw slide switches, active-high
//   irq       registered level interrupt, active-high
//
// Register map (word addresses, unused upper bits read 0):
//   0  sw_sync         read only
//   1  key_state       read only, 1 = pressed
//   2  edge_cap        read, write-1-to-clear
//   3  irq_mask        read / write
//
// Build option:
//   KEY_RELEASE_CAPTURE_EN - when defined, key releases are also captured in
//   edge_cap[2*NUM_KEYS-1:NUM_KEYS] and irq_mask widens to match. When
//   undefined, those bits read 0, ignore writes and no release logic exists.
// ---------------------------------------------------------------------------
module key_switch_input_comp #(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  key_switch_input_comp_if.slave  avs,
  input  logic [NUM_KEYS-1:0]     key_n,
  input  logic [NUM_SW-1:0]       sw,
  output logic                    irq
);

`ifdef KEY_RELEASE_CAPTURE_EN
  localparam int EDGE_W = 2 * NUM_KEYS;
`else
  localparam int EDGE_W = NUM_KEYS;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ADDR_SW   = 2'd0;
  localparam logic [1:0] ADDR_KEY  = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_MASK = 2'd3;

  // Synchroniser stages
  logic [NUM_KEYS-1:0] keyMeta_q;
  logic [NUM_KEYS-1:0] keySync_q;
  logic [NUM_SW-1:0]   swMeta_q;
  logic [NUM_SW-1:0]   swSync_q;

  // Debounce
  logic [NUM_KEYS-1:0] pressedS;
  logic [NUM_KEYS-1:0] keyState_q;
  logic [NUM_KEYS-1:0] keyState_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  // Edge capture, mask, interrupt, read data
  logic [NUM_KEYS-1:0] keyRise;
  logic [EDGE_W-1:0]   edgeEvent;
  logic [EDGE_W-1:0]   edgeClr;
  logic [EDGE_W-1:0]   edgeCap_q;
  logic [EDGE_W-1:0]   edgeCap_d;
  logic [EDGE_W-1:0]   irqMask_q;
  logic [EDGE_W-1:0]   irqMask_d;
  logic                irq_q;
  logic                irq_d;
  logic [31:0]         readData_q;
  logic [31:0]         readData_d;

  logic                writeEdge;
  logic                writeMask;

  // Only the low EDGE_W bits of writedata are meaningful; fold the rest away.
  logic unusedWriteData;
  assign unusedWriteData = ^avs.writedata;

  assign pressedS = ~keySync_q;

  // Any synchronised sample that disagrees with the debounced state advances
  // the counter; agreement (including a glitch back) restarts it. The toggle
  // happens on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_comb begin
    keyState_d = keyState_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = '0;
      if (pressedS[k] != keyState_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          keyState_d[k] = ~keyState_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end
    end
  end

  assign keyRise = keyState_d & ~keyState_q;

`ifdef KEY_RELEASE_CAPTURE_EN
  logic [NUM_KEYS-1:0] keyFall;
  assign keyFall   = ~keyState_d & keyState_q;
  assign edgeEvent = {keyFall, keyRise};
`else
  assign edgeEvent = keyRise;
`endif

  assign writeEdge = avs.write && (avs.address == ADDR_EDGE);
  assign writeMask = avs.write && (avs.address == ADDR_MASK);

  // New events are OR-ed in after the clear so a set and a clear of the same
  // bit in one cycle leaves the bit set.
  assign edgeClr   = writeEdge ? avs.writedata[EDGE_W-1:0] : '0;
  assign edgeCap_d = (edgeCap_q & ~edgeClr) | edgeEvent;
  assign irqMask_d = writeMask ? avs.writedata[EDGE_W-1:0] : irqMask_q;

  // irq is built from the registered capture and mask, so it trails any set,
  // clear or mask change by one cycle.
  assign irq_d = |(edgeCap_q & irqMask_q);

  // Read data is taken from current register contents, so a simultaneous
  // write is not visible until the following read.
  always_comb begin
    readData_d = readData_q;
    if (avs.read) begin
      case (avs.address)
        ADDR_SW:   readData_d = 32'(swSync_q);
        ADDR_KEY:  readData_d = 32'(keyState_q);
        ADDR_EDGE: readData_d = 32'(edgeCap_q);
        ADDR_MASK: readData_d = 32'(irqMask_q);
        default:   readData_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Key synchronisers come out of reset reading "released".
      keyMeta_q  <= '1;
      keySync_q  <= '1;
      swMeta_q   <= '0;
      swSync_q   <= '0;
      keyState_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
      edgeCap_q  <= '0;
      irqMask_q  <= '0;
      irq_q      <= 1'b0;
      readData_q <= '0;
    end else begin
      keyMeta_q  <= key_n;
      keySync_q  <= keyMeta_q;
      swMeta_q   <= sw;
      swSync_q   <= swMeta_q;
      keyState_q <= keyState_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      edgeCap_q  <= edgeCap_d;
      irqMask_q  <= irqMask_d;
      irq_q      <= irq_d;
      readData_q <= readData_d;
    end
  end

  assign avs.readdata = readData_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_switch_input_comp.sv
// ---------------------------------------------------------------------------
// tb_key_switch_input_comp
//
// Purpose: self-checking bench for key_switch_input_comp. A cycle-level
// behavioural model (pin delay line, run-length debounce, sticky edge word)
// predicts irq and readdata every cycle; directed sequences add fixed
// expected values for reset, switch read, glitch rejection, interrupt
// masking/clearing, set/clear collision and release capture, followed by
// randomized traffic.
//
// Honours KEY_RELEASE_CAPTURE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_key_switch_input_comp;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SW   = 18;
  localparam int DEB      = 4;
  localparam int CNT_W    = 16;

`ifdef KEY_RELEASE_CAPTURE_EN
  localparam int EDGE_W = 2 * NUM_KEYS;
  localparam logic [31:0] RELEASE_EXPECT = 32'h44;
`else
  localparam int EDGE_W = NUM_KEYS;
  localparam logic [31:0] RELEASE_EXPECT = 32'h04;
`endif

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_SW-1:0]   sw;
  logic                irq;

  int checkCount = 0;
  int errorCount = 0;

  key_switch_input_comp_if avs ();

  key_switch_input_comp #(
    .NUM_KEYS        (NUM_KEYS),
    .NUM_SW          (NUM_SW),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (avs),
    .key_n   (key_n),
    .sw      (sw),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [NUM_KEYS-1:0] pinKeyDly [2];
  logic [NUM_SW-1:0]   pinSwDly  [2];
  logic [NUM_KEYS-1:0] mKeyState;
  int                  mRun [NUM_KEYS];
  logic [EDGE_W-1:0]   mEdge;
  logic [EDGE_W-1:0]   mMask;
  logic                mIrq;
  logic [31:0]         mRead;

  // Current steady input values used by the helper tasks
  logic [NUM_KEYS-1:0] curKeyN;
  logic [NUM_SW-1:0]   curSw;
  logic                curRst;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock of the model, using the values present before the edge.
  task automatic modelStep(input logic rstN, input logic [NUM_KEYS-1:0] keyN,
                           input logic [NUM_SW-1:0] swIn, input logic rd,
                           input logic wr, input logic [1:0] addr,
                           input logic [31:0] wd);
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] release_;
    logic [2*NUM_KEYS-1:0] events;
    logic [31:0] regVal [4];
    if (!rstN) begin
      pinKeyDly[0] = '1; pinKeyDly[1] = '1;
      pinSwDly[0]  = '0; pinSwDly[1]  = '0;
      mKeyState = '0;
      for (int k = 0; k < NUM_KEYS; k++) mRun[k] = 0;
      mEdge = '0; mMask = '0; mIrq = 1'b0; mRead = '0;
      return;
    end
    regVal[0] = 32'(pinSwDly[1]);
    regVal[1] = 32'(mKeyState);
    regVal[2] = 32'(mEdge);
    regVal[3] = 32'(mMask);
    if (rd) mRead = regVal[addr];
    mIrq = |(mEdge & mMask);
    press = '0;
    release_ = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if ((pinKeyDly[1][k] == 1'b0) != mKeyState[k]) begin
        mRun[k]++;
        if (mRun[k] == DEB) begin
          mKeyState[k] = ~mKeyState[k];
          if (mKeyState[k]) press[k] = 1'b1;
          else release_[k] = 1'b1;
          mRun[k] = 0;
        end
      end else begin
        mRun[k] = 0;
      end
    end
    events = {release_, press};
    if (wr && addr == 2'd2) mEdge = mEdge & ~wd[EDGE_W-1:0];
    mEdge = mEdge | events[EDGE_W-1:0];
    if (wr && addr == 2'd3) mMask = wd[EDGE_W-1:0];
    pinKeyDly[1] = pinKeyDly[0]; pinKeyDly[0] = keyN;
    pinSwDly[1]  = pinSwDly[0];  pinSwDly[0]  = swIn;
  endtask

  task automatic applyStimulus(input logic rstN, input logic [NUM_KEYS-1:0] keyN,
                               input logic [NUM_SW-1:0] swIn, input logic rd,
                               input logic wr, input logic [1:0] addr,
                               input logic [31:0] wd);
    reset_n = rstN;
    key_n = keyN;
    sw = swIn;
    avs.read = rd;
    avs.write = wr;
    avs.address = addr;
    avs.writedata = wd;
    @(posedge clk);
    modelStep(rstN, keyN, swIn, rd, wr, addr, wd);
    #1;
    checkOutput("cycle_irq", 32'(irq), 32'(mIrq));
    checkOutput("cycle_readdata", avs.readdata, mRead);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(curRst, curKeyN, curSw, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic doRead(input logic [1:0] addr);
    applyStimulus(curRst, curKeyN, curSw, 1'b1, 1'b0, addr, 32'h0);
  endtask

  task automatic doWrite(input logic [1:0] addr, input logic [31:0] wd);
    applyStimulus(curRst, curKeyN, curSw, 1'b0, 1'b1, addr, wd);
  endtask

  initial begin
    for (int k = 0; k < NUM_KEYS; k++) mRun[k] = 0;
    pinKeyDly[0] = '1; pinKeyDly[1] = '1;
    pinSwDly[0] = '0; pinSwDly[1] = '0;
    mKeyState = '0; mEdge = '0; mMask = '0; mIrq = 1'b0; mRead = '0;

    // Reset with keys held and switches high; a pending read must not leak.
    curRst = 1'b0; curKeyN = '0; curSw = 18'h3FFFF;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, curKeyN, curSw, 1'b1, 1'b0, 2'd0, 32'h0);
      checkOutput("reset_readdata", avs.readdata, 32'h0);
      checkOutput("reset_irq", 32'(irq), 32'h0);
    end

    // Held keys appear after 2 sync + DEB debounce cycles
    curRst = 1'b1;
    cycles(5);
    doRead(2'd1);
    checkOutput("key_state_before_debounce", avs.readdata, 32'h0);
    doRead(2'd1);
    checkOutput("key_state_after_debounce", avs.readdata, 32'hF);
    doRead(2'd2);
    checkOutput("edge_after_reset_press", avs.readdata, 32'hF);

    doWrite(2'd2, 32'hFF);
    curKeyN = '1;
    cycles(8);
    doWrite(2'd2, 32'hFF);
    doRead(2'd2);
    checkOutput("edge_cleared", avs.readdata, 32'h0);

    // Switch read
    curSw = 18'h2A5A5;
    cycles(3);
    doRead(2'd0);
    checkOutput("sw_read", avs.readdata, 32'h0002A5A5);

    // Glitch on key 1, polling key_state every cycle
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1101, curSw, 1'b1, 1'b0, 2'd1, 32'h0);
    applyStimulus(1'b1, 4'b1111, curSw, 1'b1, 1'b0, 2'd1, 32'h0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 4'b1101, curSw, 1'b1, 1'b0, 2'd1, 32'h0);
    curKeyN = 4'b1101;
    doRead(2'd1);
    checkOutput("glitch_key_state", avs.readdata, 32'h2);
    doRead(2'd2);
    checkOutput("glitch_edge_cap", avs.readdata, 32'h2);

    // Interrupt mask, no clear-on-read, W1C
    doWrite(2'd3, 32'h2);
    checkOutput("irq_same_cycle_as_mask", 32'(irq), 32'h0);
    cycles(1);
    checkOutput("irq_after_mask", 32'(irq), 32'h1);
    doRead(2'd2);
    checkOutput("edge_read_1", avs.readdata, 32'h2);
    doRead(2'd2);
    checkOutput("edge_read_2", avs.readdata, 32'h2);
    doWrite(2'd2, 32'h2);
    cycles(1);
    checkOutput("irq_after_clear", 32'(irq), 32'h0);
    doRead(2'd2);
    checkOutput("edge_after_w1c", avs.readdata, 32'h0);

    // Clear lands on the same cycle as key 0's press
    curKeyN = 4'b1100;
    cycles(5);
    doWrite(2'd2, 32'h1);
    doRead(2'd2);
    checkOutput("set_wins_collision", avs.readdata, 32'h1);

    // Press and release key 2
    curKeyN = '1;
    cycles(8);
    doWrite(2'd2, 32'hFF);
    curKeyN = 4'b1011;
    cycles(8);
    curKeyN = '1;
    cycles(8);
    doRead(2'd2);
    checkOutput("release_capture", avs.readdata, RELEASE_EXPECT);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic rd, wr;
      logic [1:0] addr;
      logic [31:0] wd;
      curRst = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 9) == 0) curKeyN[$urandom_range(0, NUM_KEYS-1)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) curSw = NUM_SW'($urandom);
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 7) == 0);
      addr = 2'($urandom_range(0, 3));
      wd = $urandom;
      applyStimulus(curRst, curKeyN, curSw, rd, wr, addr, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
